uart_mm_ctrl: RTL and testbench

Host-link sequencer for the matrix multiplier, sitting between the UART transceiver and the multiplier core.
- Collects received bytes into matrix A, then matrix B (row-major).
- Starts the multiplier and waits for it to finish.
- Reads every result element and streams it back over the UART transmitter, two bytes per element, low byte first.

---
 rtl/uart_mm_ctrl.sv | 154 +++++++++++++++
 tb/tb_uart_mm_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mm_ctrl.sv
// Host-link sequencer: loads matrices A and B from UART bytes, runs the multiplier, streams results back.
// Optional build macro SYNC_HDR_EN: IDLE waits for an 8'hA5 frame header before loading A.
module uart_mm_ctrl #(
  parameter int N  = 2,
  parameter int AW = 2,
  parameter int DW = 8,
  parameter int RW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  output logic          tx_start,
  output logic [7:0]    tx_byte,
  input  logic          tx_busy,
  output logic          a_we,
  output logic          b_we,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          mm_start,
  input  logic          mm_done,
  output logic [AW-1:0] res_addr,
  input  logic [RW-1:0] res_data,
  output logic          busy,
  output logic          err_ovr,
  output logic [3:0]    dbg_state
);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, START, WAIT, RD,
    TX_LO, TX_LO_W, TX_HI, TX_HI_W, NEXT
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(N * N - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] res_addr_q, res_addr_d;
  logic [RW-1:0] rres_q;
  logic          err_q, err_d;
  logic          mm_start_q;
  logic [7:0]    lo_byte, hi_byte;

  assign lo_byte   = 8'(rres_q);
  assign hi_byte   = 8'(rres_q >> 8);
  assign wr_addr   = cnt_q;
  assign res_addr  = res_addr_q;
  assign mm_start  = mm_start_q;
  assign err_ovr   = err_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_addr_d = res_addr_q;
    err_d      = err_q;
    a_we       = 1'b0;
    b_we       = 1'b0;
    wr_data    = '0;
    tx_start   = 1'b0;
    tx_byte    = 8'h00;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
`ifdef SYNC_HDR_EN
          if (rx_byte == 8'hA5) begin
            state_d = LOAD_A;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
`else
          a_we    = 1'b1;
          wr_data = DW'(rx_byte);
          cnt_d   = AW'(1);
          state_d = LOAD_A;
          err_d   = 1'b0;
`endif
        end
      end
      LOAD_A, LOAD_B: begin
        if (rx_valid) begin
          a_we    = (state_q == LOAD_A);
          b_we    = (state_q == LOAD_B);
          wr_data = DW'(rx_byte);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = (state_q == LOAD_A) ? LOAD_B : START;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (mm_done) begin
          res_addr_d = '0;
          state_d    = RD;
        end
      end
      RD: state_d = TX_LO;
      // tx_start is held until the transmitter acknowledges with tx_busy.
      TX_LO: begin
        tx_start = 1'b1;
        tx_byte  = lo_byte;
        if (tx_busy) state_d = TX_LO_W;
      end
      TX_LO_W: begin
        tx_byte = lo_byte;
        if (!tx_busy) state_d = TX_HI;
      end
      TX_HI: begin
        tx_start = 1'b1;
        tx_byte  = hi_byte;
        if (tx_busy) state_d = TX_HI_W;
      end
      TX_HI_W: begin
        tx_byte = hi_byte;
        if (!tx_busy) state_d = NEXT;
      end
      NEXT: begin
        if (res_addr_q == LAST) begin
          res_addr_d = '0;
          state_d    = IDLE;
        end else begin
          res_addr_d = res_addr_q + AW'(1);
          state_d    = RD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rx_valid && !(state_q inside {IDLE, LOAD_A, LOAD_B})) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      res_addr_q <= '0;
      rres_q     <= '0;
      err_q      <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      res_addr_q <= res_addr_d;
      err_q      <= err_d;
      // Registered so the start pulse lands two cycles after the last B byte.
      mm_start_q <= (state_q == START);
      if (state_q == RD) rres_q <= res_data;
    end
  end

endmodule

// File: tb/tb_uart_mm_ctrl.sv
// Directed bench for uart_mm_ctrl (N=2): load order, start latency, result stream, stall, overrun, reset.
module tb_uart_mm_ctrl;
  localparam int N  = 2;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          tx_busy = 1'b0;
  logic          a_we, b_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mm_start;
  logic          mm_done = 1'b0;
  logic [AW-1:0] res_addr;
  logic [RW-1:0] res_data;
  logic          busy, err_ovr;
  logic [3:0]    dbg_state;

  logic [RW-1:0] res_mem [4];
  logic [10:0]   exp_q [$];
  logic [10:0]   got_q [$];
  int            total = 0;
  int            bad = 0;
  int            mm_pulses = 0;

  uart_mm_ctrl #(.N(N), .AW(AW), .DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_start(tx_start), .tx_byte(tx_byte), .tx_busy(tx_busy),
    .a_we(a_we), .b_we(b_we), .wr_addr(wr_addr), .wr_data(wr_data),
    .mm_start(mm_start), .mm_done(mm_done), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .err_ovr(err_ovr), .dbg_state(dbg_state)
  );

  // clock / result memory model
  always #5 clk = ~clk;
  assign res_data = res_mem[res_addr];

  // write and start monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (!rst) begin
      if (a_we) got_q.push_back({1'b0, wr_addr, wr_data});
      if (b_we) got_q.push_back({1'b1, wr_addr, wr_data});
      if (mm_start) mm_pulses++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic load(input logic [7:0] base);
    logic [7:0]  d;
    logic [10:0] g, e;
    got_q.delete();
    exp_q.delete();
`ifdef SYNC_HDR_EN
    send_byte(8'hA5);
    tick();
`endif
    for (int i = 0; i < 8; i++) begin
      d = base + 8'(i);
      exp_q.push_back({(i >= 4) ? 1'b1 : 1'b0, 2'(i % 4), d});
      send_byte(d);
      if (i == 0) chk("err_clr_on_load", {31'd0, err_ovr}, 32'd0);
      if (i != 7) tick();
    end
    chk("mm_start_lat1", {31'd0, mm_start}, 32'd0);
    tick();
    chk("mm_start_lat2", {31'd0, mm_start}, 32'd1);
    tick();
    chk("mm_start_width", {31'd0, mm_start}, 32'd0);
    chk("wr_count", got_q.size(), 32'd8);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk("wr_entry", {21'd0, g}, {21'd0, e});
    end
  endtask

  task automatic wait_tx_start();
    int n = 0;
    while (tx_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("tx_start_seen", {31'd0, tx_start}, 32'd1);
  endtask

  task automatic serve(input logic [7:0] exp, input int stall, input int blen);
    wait_tx_start();
    chk("tx_byte", {24'd0, tx_byte}, {24'd0, exp});
    if (stall > 0) begin
      repeat (stall) tick();
      chk("stall_start", {31'd0, tx_start}, 32'd1);
      chk("stall_byte", {24'd0, tx_byte}, {24'd0, exp});
    end
    tx_busy = 1'b1;
    tick();
    chk("start_drop", {31'd0, tx_start}, 32'd0);
    repeat (blen - 1) tick();
    chk("byte_in_busy", {24'd0, tx_byte}, {24'd0, exp});
    tx_busy = 1'b0;
    tick();
  endtask

  task automatic run_results(input logic [15:0] r0, input logic [15:0] r1,
                             input logic [15:0] r2, input logic [15:0] r3,
                             input int stall0, input logic exp_err);
    logic [15:0] r [4];
    r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
    for (int i = 0; i < 4; i++) res_mem[i] = r[i];
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    chk("tx_lat1", {31'd0, tx_start}, 32'd0);
    tick();
    chk("tx_lat2", {31'd0, tx_start}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      serve(r[i][7:0], (i == 0) ? stall0 : 0, (i == 0) ? 5 : 2);
      serve(r[i][15:8], 0, 2);
    end
    tick();
    chk("idle_after_tx", {31'd0, busy}, 32'd0);
    chk("err_after_tx", {31'd0, err_ovr}, {31'd0, exp_err});
  endtask

  initial begin
    for (int i = 0; i < 4; i++) res_mem[i] = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    chk("rst_we", {30'd0, a_we, b_we}, 32'd0);
    chk("rst_mm_start", {31'd0, mm_start}, 32'd0);
    chk("rst_err", {31'd0, err_ovr}, 32'd0);
    chk("rst_state", {28'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    tick();

`ifdef SYNC_HDR_EN
    send_byte(8'h11);
    tick();
    chk("hdr_junk_busy", {31'd0, busy}, 32'd0);
    chk("hdr_junk_err", {31'd0, err_ovr}, 32'd0);
    chk("hdr_junk_nowr", got_q.size(), 32'd0);
`endif

    // run 1: load 1..8, overrun in WAIT, stalled first byte
    load(8'h01);
    tick();
    chk("wait_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h99);
    tick();
    chk("ovr_set", {31'd0, err_ovr}, 32'd1);
    chk("ovr_nowr", got_q.size(), 32'd0);
    run_results(16'h0013, 16'h0016, 16'h002B, 16'h0032, 20, 1'b1);
    chk("mm_pulses_1", mm_pulses, 32'd1);

    // run 2: reset while waiting on the high-byte frame
    load(8'h21);
    tick();
    send_byte(8'h77);
    tick();
    chk("ovr_set_2", {31'd0, err_ovr}, 32'd1);
    res_mem[0] = 16'h1234; res_mem[1] = 16'h5678; res_mem[2] = 16'h9ABC; res_mem[3] = 16'hDEF0;
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    serve(8'h34, 0, 2);
    wait_tx_start();
    chk("hi_byte_pre_rst", {24'd0, tx_byte}, 32'h12);
    tx_busy = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_busy = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("mid_rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    chk("mid_rst_we", {30'd0, a_we, b_we}, 32'd0);
    chk("mid_rst_mm_start", {31'd0, mm_start}, 32'd0);
    chk("mid_rst_err", {31'd0, err_ovr}, 32'd0);
    chk("mid_rst_res_addr", {30'd0, res_addr}, 32'd0);
    tick();

    // run 3: fresh load after reset, full-range result values
    load(8'h41);
    tick();
    run_results(16'h1234, 16'hABCD, 16'h00FF, 16'h8001, 0, 1'b0);
    chk("mm_pulses_3", mm_pulses, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
